// File: rtl/trading_pkg.sv
// Shared definitions for the trade-report transmit framer: frame FSM states,
// message-type constant, frame lengths and a payload byte selector.
package trading_pkg;

    localparam logic [7:0] MSG_TYPE_TRADE  = 8'h54;
    localparam int         FRAME_LEN_SEQ   = 7;
    localparam int         FRAME_LEN_NOSEQ = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TYPE   = 3'd1,
        ST_SEQ_HI = 3'd2,
        ST_SEQ_LO = 3'd3,
        ST_PAY0   = 3'd4,
        ST_PAY1   = 3'd5,
        ST_PAY2   = 3'd6,
        ST_PAY3   = 3'd7
    } frame_state_e;

    // Payload bytes go out most-significant first (network order).
    function automatic logic [7:0] trade_byte(input logic [31:0] info, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = info[31:24];
            2'd1:    b = info[23:16];
            2'd2:    b = info[15:8];
            default: b = info[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_count_nxt;

    // A push against a full buffer is refused even if a pop happens on the same edge.
    assign w_push_ok   = i_push && !r_full;
    assign w_pop_ok    = i_pop && !r_empty;
    assign w_count_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

    // NOTE: storage has no reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/trade_tx_framer.sv
// Buffers trade reports and serialises each into an AXI-Stream byte frame.
// Define TRADE_TX_SEQNUM_EN to insert a 16-bit sequence number after the type byte.
module trade_tx_framer
    import trading_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] MSG_TYPE   = MSG_TYPE_TRADE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trade_valid,
    input  logic [31:0] trade_info,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        fifo_full,
    output logic [15:0] drop_count
);

    frame_state_e r_state;
    frame_state_e w_state_nxt;
    logic [31:0]  r_frame;
    logic [7:0]   r_tdata;
    logic         r_tvalid;
    logic         r_tlast;
    logic [15:0]  r_drop_count;
    logic [31:0]  w_fifo_rdata;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_pop;
    logic         w_hs;
    logic [7:0]   w_tdata_nxt;
    logic         w_tvalid_nxt;
    logic         w_tlast_nxt;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (trade_valid),
        .i_pop   (w_pop),
        .i_wdata (trade_info),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_hs = r_tvalid && tx_axis_tready;

`ifdef TRADE_TX_SEQNUM_EN
    logic [15:0] r_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= 16'h0000;
        end else if (r_state == ST_PAY3 && w_hs) begin
            r_seq <= r_seq + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_TYPE;
                    w_pop       = 1'b1;
                end
            end
`ifdef TRADE_TX_SEQNUM_EN
            ST_TYPE:   if (w_hs) w_state_nxt = ST_SEQ_HI;
            ST_SEQ_HI: if (w_hs) w_state_nxt = ST_SEQ_LO;
            ST_SEQ_LO: if (w_hs) w_state_nxt = ST_PAY0;
`else
            ST_TYPE:   if (w_hs) w_state_nxt = ST_PAY0;
`endif
            ST_PAY0:   if (w_hs) w_state_nxt = ST_PAY1;
            ST_PAY1:   if (w_hs) w_state_nxt = ST_PAY2;
            ST_PAY2:   if (w_hs) w_state_nxt = ST_PAY3;
            ST_PAY3: begin
                // Chain straight into the next frame so back-to-back reports leave no gap.
                if (w_hs) begin
                    if (!w_fifo_empty) begin
                        w_state_nxt = ST_TYPE;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so tready never reaches them combinationally.
    always_comb begin
        w_tvalid_nxt = (w_state_nxt != ST_IDLE);
        w_tlast_nxt  = (w_state_nxt == ST_PAY3);
        w_tdata_nxt  = 8'h00;
        case (w_state_nxt)
            ST_TYPE:   w_tdata_nxt = MSG_TYPE;
`ifdef TRADE_TX_SEQNUM_EN
            ST_SEQ_HI: w_tdata_nxt = r_seq[15:8];
            ST_SEQ_LO: w_tdata_nxt = r_seq[7:0];
`endif
            ST_PAY0:   w_tdata_nxt = trade_byte(r_frame, 2'd0);
            ST_PAY1:   w_tdata_nxt = trade_byte(r_frame, 2'd1);
            ST_PAY2:   w_tdata_nxt = trade_byte(r_frame, 2'd2);
            ST_PAY3:   w_tdata_nxt = trade_byte(r_frame, 2'd3);
            default:   w_tdata_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame      <= 32'h0;
            r_tdata      <= 8'h00;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            if (w_pop) r_frame <= w_fifo_rdata;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            if (trade_valid && w_fifo_full && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign tx_axis_tdata  = r_tdata;
    assign tx_axis_tvalid = r_tvalid;
    assign tx_axis_tlast  = r_tlast;
    assign fifo_full      = w_fifo_full;
    assign drop_count     = r_drop_count;

endmodule

// File: tb/tb_trade_tx_framer.sv
// Self-checking bench for trade_tx_framer: byte-queue reference model compared every
// cycle, plus literal frame vectors, backpressure, overflow, mid-frame reset and seq wrap.
module tb_trade_tx_framer;

    localparam int DEPTH = 8;
`ifdef TRADE_TX_SEQNUM_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif
    localparam int FLEN = SEQ_ON ? 7 : 5;

    logic        clk;
    logic        rst_n;
    logic        trade_valid;
    logic [31:0] trade_info;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        fifo_full;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    trade_tx_framer #(
        .FIFO_DEPTH (DEPTH),
        .MSG_TYPE   (8'h54)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trade_valid    (trade_valid),
        .trade_info     (trade_info),
        .tx_axis_tdata  (tdata),
        .tx_axis_tvalid (tvalid),
        .tx_axis_tready (tready),
        .tx_axis_tlast  (tlast),
        .fifo_full      (fifo_full),
        .drop_count     (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: waiting reports, and the bytes still owed for the frame on the wire.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    int          m_drops;
    logic [15:0] m_seq;
    logic        force_seq_req;
    logic        cmp_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_cur.delete();
            m_drops = 0;
            m_seq   = 16'h0000;
        end else begin
            bit          full_pre;
            bit          busy;
            bit          hs;
            bit          last_hs;
            bit          take;
            logic [31:0] info;
            full_pre = (m_fifo.size() == DEPTH);
            busy     = (m_cur.size() != 0);
            hs       = busy && tready;
            last_hs  = hs && (m_cur.size() == 1);
            take     = (!busy || last_hs) && (m_fifo.size() != 0);
            if (force_seq_req) m_seq = 16'hFFFF;
            if (hs) void'(m_cur.pop_front());
            if (last_hs && SEQ_ON) m_seq = m_seq + 16'd1;
            if (take) begin
                info = m_fifo.pop_front();
                m_cur.push_back(8'h54);
                if (SEQ_ON) begin
                    m_cur.push_back(m_seq[15:8]);
                    m_cur.push_back(m_seq[7:0]);
                end
                m_cur.push_back(info[31:24]);
                m_cur.push_back(info[23:16]);
                m_cur.push_back(info[15:8]);
                m_cur.push_back(info[7:0]);
            end
            if (trade_valid) begin
                if (full_pre) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_fifo.push_back(trade_info);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("m_tvalid", tvalid, m_cur.size() != 0);
            if (m_cur.size() != 0) begin
                check("m_tdata", tdata, m_cur[0]);
                check("m_tlast", tlast, m_cur.size() == 1);
            end
            check("m_fifo_full", fifo_full, m_fifo.size() == DEPTH);
            check("m_drop_count", drop_count, m_drops);
        end
    end

    // Capture of accepted bytes: outputs latched on the falling edge, handshake taken at the rising edge.
    logic [7:0] cap_data[$];
    logic       cap_last[$];
    int         cap_cyc[$];
    logic       l_valid;
    logic       l_last;
    logic [7:0] l_data;
    int         cyc = 0;

    always @(negedge clk) begin
        l_valid = tvalid;
        l_data  = tdata;
        l_last  = tlast;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n && l_valid && tready) begin
            cap_data.push_back(l_data);
            cap_last.push_back(l_last);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic strobe(input logic [31:0] info);
        trade_valid = 1'b1;
        trade_info  = info;
        @(negedge clk);
        trade_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tvalid) check({tag, "_valid_timeout"}, n, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        trade_valid = 1'b0;
        tready      = 1'b1;
        while ((m_cur.size() != 0 || m_fifo.size() != 0 || tvalid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({tag, "_drain_timeout"}, n, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input int base, input logic [7:0] exp_b[$]);
        if (cap_data.size() < base + exp_b.size()) begin
            check({tag, "_len"}, cap_data.size() - base, exp_b.size());
            return;
        end
        for (int i = 0; i < exp_b.size(); i++) begin
            check({tag, "_data"}, cap_data[base+i], exp_b[i]);
            check({tag, "_last"}, cap_last[base+i], (i % FLEN) == FLEN - 1);
        end
    endtask

    task automatic expect_frame(input string tag, input int base, input logic [15:0] seq,
                                input logic [31:0] info);
        logic [7:0] exp_b[$];
        exp_b.push_back(8'h54);
        if (SEQ_ON) begin
            exp_b.push_back(seq[15:8]);
            exp_b.push_back(seq[7:0]);
        end
        exp_b.push_back(info[31:24]);
        exp_b.push_back(info[23:16]);
        exp_b.push_back(info[15:8]);
        exp_b.push_back(info[7:0]);
        check_bytes(tag, base, exp_b);
    endtask

    initial begin
        logic [7:0] lit[$];
        int         base;
        int         base2;
        int         nlast;
        int         k;

        rst_n         = 1'b0;
        trade_valid   = 1'b0;
        trade_info    = 32'h0;
        tready        = 1'b0;
        cmp_en        = 1'b0;
        force_seq_req = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_full", fifo_full, 1'b0);
        check("rst_drops", drop_count, 16'h0000);

        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single frame, tready high: latency and literal bytes.
        tready = 1'b1;
        base   = cap_data.size();
        strobe(32'h00018001);
        check("lat_edge_n_tvalid", tvalid, 1'b0);
        @(negedge clk);
        check("lat_edge_n1_tvalid", tvalid, 1'b1);
        check("lat_edge_n1_tdata", tdata, 8'h54);
        drain("single");
        if (SEQ_ON) lit = '{8'h54, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80, 8'h01};
        else        lit = '{8'h54, 8'h00, 8'h01, 8'h80, 8'h01};
        check_bytes("single", base, lit);

        // Two back-to-back frames must be contiguous on the wire.
        reset_pulse();
        base = cap_data.size();
        trade_valid = 1'b1;
        trade_info  = 32'h00FF000A;
        @(negedge clk);
        trade_info  = 32'h00018001;
        @(negedge clk);
        trade_valid = 1'b0;
        drain("pair");
        if (SEQ_ON) lit = '{8'h54, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h0A,
                            8'h54, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h01};
        else        lit = '{8'h54, 8'h00, 8'hFF, 8'h00, 8'h0A,
                            8'h54, 8'h00, 8'h01, 8'h80, 8'h01};
        check_bytes("pair", base, lit);
        if (cap_cyc.size() >= base + 2 * FLEN) begin
            check("pair_contiguous", cap_cyc[base+2*FLEN-1] - cap_cyc[base], 2 * FLEN - 1);
        end else begin
            check("pair_count", cap_cyc.size() - base, 2 * FLEN);
        end

        // Backpressure while PAY1 is presented.
        base = cap_data.size();
        strobe(32'h00018001);
        wait_valid("bp");
        k = SEQ_ON ? 4 : 2;
        repeat (k) @(negedge clk);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_tdata", tdata, 8'h01);
            check("bp_hold_tvalid", tvalid, 1'b1);
            @(negedge clk);
        end
        drain("bp");
        expect_frame("bp", base, 16'd2, 32'h00018001);
        check("bp_no_extra", cap_data.size() - base, FLEN);

        // Overflow: ten strobes with the sink stalled.
        reset_pulse();
        tready = 1'b0;
        base   = cap_data.size();
        for (int i = 1; i <= 10; i++) begin
            trade_valid = 1'b1;
            trade_info  = 32'h00001000 + i;
            @(negedge clk);
        end
        trade_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_full", fifo_full, 1'b1);
        check("ovf_drops", drop_count, 16'd1);
        drain("ovf");
        nlast = 0;
        for (int i = base; i < cap_data.size(); i++) begin
            if (cap_last[i]) begin
                nlast++;
                check("ovf_frame_order", cap_data[i], nlast);
            end
        end
        check("ovf_frames", nlast, 9);
        check("ovf_full_after", fifo_full, 1'b0);

        // Reset asserted while PAY2 is on the wire.
        reset_pulse();
        tready = 1'b1;
        base   = cap_data.size();
        strobe(32'h00018001);
        wait_valid("rstmid");
        k = SEQ_ON ? 5 : 3;
        repeat (k) @(negedge clk);
        check("rstmid_pay2", tdata, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tvalid", tvalid, 1'b0);
        check("rstmid_tlast", tlast, 1'b0);
        check("rstmid_tdata", tdata, 8'h00);
        check("rstmid_full", fifo_full, 1'b0);
        check("rstmid_drops", drop_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nlast = 0;
        for (int i = base; i < cap_data.size(); i++) if (cap_last[i]) nlast++;
        check("rstmid_no_tlast", nlast, 0);
        base2 = cap_data.size();
        strobe(32'hA1B2C3D4);
        drain("rstmid");
        expect_frame("rstmid_after", base2, 16'h0000, 32'hA1B2C3D4);

`ifdef TRADE_TX_SEQNUM_EN
        // Sequence wrap from FFFF to 0000.
        reset_pulse();
        force dut.r_seq = 16'hFFFF;
        force_seq_req   = 1'b1;
        @(negedge clk);
        release dut.r_seq;
        force_seq_req = 1'b0;
        base = cap_data.size();
        trade_valid = 1'b1;
        trade_info  = 32'h11223344;
        @(negedge clk);
        trade_info  = 32'h55667788;
        @(negedge clk);
        trade_valid = 1'b0;
        drain("wrap");
        expect_frame("wrap_ffff", base, 16'hFFFF, 32'h11223344);
        expect_frame("wrap_0000", base + FLEN, 16'h0000, 32'h55667788);
`endif

        // Randomised traffic: congested phase, then a lightly loaded phase.
        reset_pulse();
        for (int i = 0; i < 3000; i++) begin
            trade_valid = ($urandom_range(99) < 40);
            trade_info  = $urandom;
            tready      = (i < 1000) ? ($urandom_range(99) < 20) : ($urandom_range(99) < 75);
            @(negedge clk);
        end
        drain("rand");
        check("rand_idle_tvalid", tvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trade_tx_framer.md
TRADE_TX_FRAMER -- requirements
Module: trade_tx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, trade-report buffer depth in entries; SHALL be a power of two, >= 2.
REQ-002 Parameter MSG_TYPE, default 8'h54, message-type byte leading every frame.
REQ-003 clk  input  1  single clock for all logic (engine domain, 200 MHz).
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 trade_valid  input  1  one-cycle strobe: trade_info valid this cycle.
REQ-006 trade_info  input  32  trade report from order book engine.
REQ-007 tx_axis_tdata  output  8  AXI-Stream byte out.
REQ-008 tx_axis_tvalid  output  1  byte valid.
REQ-009 tx_axis_tready  input  1  downstream accepts byte.
REQ-010 tx_axis_tlast  output  1  last byte of frame.
REQ-011 fifo_full  output  1  buffer holds FIFO_DEPTH entries.
REQ-012 drop_count  output  16  trade reports discarded due to full buffer.

Function
REQ-013 Each trade_valid cycle SHALL push trade_info into FIFO unless fifo_full is high that same cycle (full evaluated before any same-cycle pop); a refused push SHALL increment drop_count, saturating at 16'hFFFF.
REQ-014 FSM states: IDLE, TYPE, SEQ_HI, SEQ_LO, PAY0, PAY1, PAY2, PAY3.
REQ-015 IDLE -> TYPE when FIFO non-empty; FIFO pop and capture of the entry into a frame register SHALL occur on that transition.
REQ-016 Frame bytes in order: MSG_TYPE, [seq[15:8], seq[7:0] if enabled], trade_info[31:24], [23:16], [15:8], [7:0] (network/big-endian order).
REQ-017 State SHALL advance only on tvalid && tready; tdata, tvalid, tlast SHALL stay stable while tvalid && !tready.
REQ-018 tx_axis_tvalid SHALL be high in every state except IDLE; tlast high only in PAY3.
REQ-019 PAY3 handshake: go TYPE (with pop) if FIFO non-empty, else IDLE; back-to-back frames SHALL have no idle cycle.
REQ-020 Latency: trade_valid sampled at edge N with FIFO empty and FSM IDLE -> first byte (MSG_TYPE) presented with tvalid after edge N+1.
REQ-021 All outputs SHALL be registered; no combinational path tready -> tvalid/tdata.
REQ-022 fifo_full SHALL reflect occupancy after the current edge's push/pop.

Reset
REQ-023 On rst_n low: FSM IDLE, FIFO empty, tvalid=0, tlast=0, tdata=8'h00, fifo_full=0, drop_count=0, seq=0, immediately and asynchronously.
REQ-024 Reset mid-frame SHALL abandon the frame with no tlast; first frame after release starts at MSG_TYPE with seq=0.

Configuration
REQ-025 Macro TRADE_TX_SEQNUM_EN defined: SEQ_HI/SEQ_LO emitted (7-byte frame); 16-bit seq increments on each PAY3 handshake, wraps 16'hFFFF -> 16'h0000.
REQ-026 Macro undefined: SEQ states and seq register absent; frame is 5 bytes (TYPE -> PAY0).

Structure
REQ-027 Shared package trading_pkg SHALL hold the FSM state enum, MSG_TYPE_TRADE constant (8'h54) and frame length constants.
REQ-028 FIFO SHALL be a separate sub-module sync_fifo (single clock, registered full/empty, parameterised width/depth).

Verification
REQ-029 Seq off, tready=1, trade_info=32'h00018001 -> bytes 54,00,01,80,01, tlast on 01, first tvalid two edges after strobe.
REQ-030 Seq on, two strobes 32'h00FF000A then 32'h00018001, tready=1 -> 54,00,00,00,FF,00,0A then 54,00,01,00,01,80,01 contiguous.
REQ-031 Backpressure: tready low 3 cycles while PAY1 presented -> tdata stays 8'h01 (for 32'h00018001), no byte lost/duplicated.
REQ-032 Overflow: tready=0, 10 back-to-back strobes, FIFO_DEPTH=8 -> one entry popped into frame register, FIFO holds 8, fifo_full=1, drop_count=1; releasing tready yields 9 frames.
REQ-033 Reset asserted during PAY2 -> outputs to reset values immediately; after release, a new strobe yields a complete frame with seq=0000.
REQ-034 Seq wrap: force 65536 frames (or preload via hierarchical force to 16'hFFFF) -> frame seq FFFF followed by 0000.
